// File: rtl/rcv_pkg.sv
// rcv_pkg: shared types and constants for the UART receive controller.
package rcv_pkg;
   typedef enum logic [2:0] {IDLE, START, RECV, STOP_CHK, LOAD} rcv_state_t;
   localparam int RCV_DATA_BITS = 8;
   localparam int FRAME_BITS = RCV_DATA_BITS + 1;
   localparam logic [31:0] RX_IDLE_VAL = '1;
endpackage

// File: rtl/rcv_sync_edge.sv
// rcv_sync_edge: serial_in synchroniser plus 1->0 start-edge detector.
module rcv_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic start_edge_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign sync_o       = sync_q[SYNC_STAGES-1];
   assign start_edge_o = prev_q & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/rcv_ctrl.sv
// rcv_ctrl: UART receive FSM, shift register and host-side status flags.
// Optional RCV_BREAK_DETECT_EN adds break_detect and a wait-for-idle-line after a break.
module rcv_ctrl
   import rcv_pkg::*;
#(
   parameter int DATA_BITS   = FRAME_BITS - 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   input  logic                 shift_enable,
   input  logic                 packet_done,
   input  logic                 data_read,
   output logic                 enable_timer,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 overrun_error,
`ifdef RCV_BREAK_DETECT_EN
   output logic                 break_detect,
`endif
   output logic                 framing_error
);
   rcv_state_t           state_q, state_d;
   logic [DATA_BITS:0]   sreg_q, sreg_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 ready_q, ready_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic                 sync_in, start_edge, wait_idle;
`ifdef RCV_BREAK_DETECT_EN
   logic                 brk_q, brk_d, wait_q, wait_d;
   assign wait_idle    = wait_q;
   assign break_detect = brk_q;
`else
   assign wait_idle = 1'b0;
`endif

   rcv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst         (rst),
      .d_i         (serial_in),
      .sync_o      (sync_in),
      .start_edge_o(start_edge)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sreg_q    <= '1;
         rx_data_q <= DATA_BITS'(RX_IDLE_VAL);
         ready_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef RCV_BREAK_DETECT_EN
         brk_q     <= 1'b0;
         wait_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         rx_data_q <= rx_data_d;
         ready_q   <= ready_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
`ifdef RCV_BREAK_DETECT_EN
         brk_q     <= brk_d;
         wait_q    <= wait_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      rx_data_d = rx_data_q;
      ready_d   = data_read ? 1'b0 : ready_q;
      ovr_d     = data_read ? 1'b0 : ovr_q;
      ferr_d    = ferr_q;
`ifdef RCV_BREAK_DETECT_EN
      brk_d     = brk_q;
      wait_d    = sync_in ? 1'b0 : wait_q;
`endif
      case (state_q)
         IDLE: state_d = (start_edge && !wait_idle) ? START : IDLE;
         START: begin
            ferr_d  = 1'b0;
            sreg_d  = '1;
            state_d = RECV;
`ifdef RCV_BREAK_DETECT_EN
            brk_d   = 1'b0;
`endif
         end
         RECV: begin
            sreg_d  = shift_enable ? {sync_in, sreg_q[DATA_BITS:1]} : sreg_q;
            state_d = packet_done ? STOP_CHK : RECV;
         end
         STOP_CHK: begin
`ifdef RCV_BREAK_DETECT_EN
            if (sreg_q == '0) begin
               brk_d  = 1'b1;
               wait_d = 1'b1;
            end
`endif
            ferr_d  = ~sreg_q[DATA_BITS];
            state_d = sreg_q[DATA_BITS] ? LOAD : IDLE;
         end
         LOAD: begin
            // A read in this same cycle consumes the old byte, so no overrun.
            rx_data_d = sreg_q[DATA_BITS-1:0];
            ready_d   = 1'b1;
            ovr_d     = (ready_q && !data_read) ? 1'b1 : ovr_d;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enable_timer  = (state_q == RECV);
   assign rx_data       = rx_data_q;
   assign data_ready    = ready_q;
   assign overrun_error = ovr_q;
   assign framing_error = ferr_q;
endmodule

// File: tb/tb_rcv_ctrl.sv
// tb_rcv_ctrl: scoreboard bench for rcv_ctrl with a 10-clk bit timer model.
module tb_rcv_ctrl;
   typedef struct packed {
      logic [7:0] rx;
      logic       dr, ov, fe, bk;
   } exp_t;

   logic       clk = 1'b0, rst = 1'b1, serial_in = 1'b1, data_read = 1'b0;
   logic       shift_enable, packet_done, enable_timer;
   logic [7:0] rx_data;
   logic       data_ready, overrun_error, framing_error;
`ifdef RCV_BREAK_DETECT_EN
   logic       break_detect;
`endif
   int         total = 0, bad = 0;
   int         cnt = 0, ns = 0;
   logic       pd_q = 1'b0, pd_prev = 1'b0;
   exp_t       sb[$];
   exp_t       e;

   rcv_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .shift_enable (shift_enable),
      .packet_done  (packet_done),
      .data_read    (data_read),
      .enable_timer (enable_timer),
      .rx_data      (rx_data),
      .data_ready   (data_ready),
      .overrun_error(overrun_error),
`ifdef RCV_BREAK_DETECT_EN
      .break_detect (break_detect),
`endif
      .framing_error(framing_error)
   );

   always #5 clk = ~clk;

   // Timer model: strobe 11 clks after enable, then every 10; done after 9 strobes.
   assign shift_enable = enable_timer && cnt >= 11 && (cnt % 10) == 1 && ns < 9;
   assign packet_done  = pd_q;
   always @(posedge clk) begin
      if (!enable_timer) begin
         cnt  <= 0;
         ns   <= 0;
         pd_q <= 1'b0;
      end else begin
         cnt <= cnt + 1;
         if (shift_enable) begin
            ns <= ns + 1;
            if (ns == 8) pd_q <= 1'b1;
         end
      end
   end

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", n, a, x, $time);
      end
   endtask

   // Monitor: on packet_done rise, check timer stop then the outcome two cycles later.
   initial begin
      forever begin
         @(negedge clk);
         if (packet_done && !pd_prev) begin
            @(posedge clk);
            @(negedge clk);
            chk("en_low_stopchk", 8'(enable_timer), 8'd0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
               chk("unexpected_frame", 8'd1, 8'd0);
            end else begin
               e = sb.pop_front();
               chk("rx_data", rx_data, e.rx);
               chk("data_ready", 8'(data_ready), 8'(e.dr));
               chk("overrun_error", 8'(overrun_error), 8'(e.ov));
               chk("framing_error", 8'(framing_error), 8'(e.fe));
`ifdef RCV_BREAK_DETECT_EN
               chk("break_detect", 8'(break_detect), 8'(e.bk));
`endif
            end
         end
         pd_prev = packet_done;
      end
   end

   task automatic drive(input logic b, input int n);
      serial_in = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input bit rd_in_load, input exp_t x);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      sb.push_back(x);
      fork
         begin
            for (int i = 0; i < 10; i++) drive(f[i], 10);
            drive(1'b1, 10);
         end
         begin
            if (rd_in_load) begin
               @(posedge packet_done);
               @(posedge clk);
               @(posedge clk);
               #1 data_read = 1'b1;
               @(posedge clk);
               #1 data_read = 1'b0;
            end
         end
      join
   endtask

   task automatic rd_pulse(input string n);
      data_read = 1'b1;
      @(posedge clk);
      #1 data_read = 1'b0;
      @(negedge clk);
      chk({n, "_ready_clr"}, 8'(data_ready), 8'd0);
      chk({n, "_ovr_clr"}, 8'(overrun_error), 8'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string n);
      chk({n, "_rx"}, rx_data, 8'hFF);
      chk({n, "_ready"}, 8'(data_ready), 8'd0);
      chk({n, "_ovr"}, 8'(overrun_error), 8'd0);
      chk({n, "_ferr"}, 8'(framing_error), 8'd0);
      chk({n, "_en"}, 8'(enable_timer), 8'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset("reset");
      @(posedge clk);
      #1;
      drive(1'b1, 10);
      send(8'h3C, 1'b0, 1'b0, '{rx: 8'hFF, dr: 1'b0, ov: 1'b0, fe: 1'b1, bk: 1'b0});
      send(8'h11, 1'b1, 1'b0, '{rx: 8'h11, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
      rd_pulse("read11");
      send(8'hA5, 1'b1, 1'b0, '{rx: 8'hA5, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
      rd_pulse("readA5");
      send(8'h01, 1'b1, 1'b0, '{rx: 8'h01, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
      send(8'h02, 1'b1, 1'b0, '{rx: 8'h02, dr: 1'b1, ov: 1'b1, fe: 1'b0, bk: 1'b0});
      rd_pulse("read_ovr");
      send(8'h33, 1'b1, 1'b0, '{rx: 8'h33, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
      send(8'h55, 1'b1, 1'b1, '{rx: 8'h55, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
      // Abort a 0x7E frame with rst partway through its 5th data bit.
      drive(1'b0, 10);
      for (int i = 0; i < 4; i++) drive(1'(8'h7E >> i), 10);
      drive(1'(8'h7E >> 4), 5);
      chk("midframe_en_high", 8'(enable_timer), 8'd1);
      rst = 1'b1;
      #1;
      chk_reset("midframe_rst");
      serial_in = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b1, 20);
      send(8'h7E, 1'b1, 1'b0, '{rx: 8'h7E, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
`ifdef RCV_BREAK_DETECT_EN
      rd_pulse("read7E");
      sb.push_back('{rx: 8'h7E, dr: 1'b0, ov: 1'b0, fe: 1'b1, bk: 1'b1});
      drive(1'b0, 130);
      chk("break_hold_en", 8'(enable_timer), 8'd0);
      chk("break_hold_bk", 8'(break_detect), 8'd1);
      drive(1'b1, 20);
      send(8'h42, 1'b1, 1'b0, '{rx: 8'h42, dr: 1'b1, ov: 1'b0, fe: 1'b0, bk: 1'b0});
`endif
      drive(1'b1, 20);
      while (sb.size() != 0) begin
         void'(sb.pop_front());
         chk("missing_frame", 8'd1, 8'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rcv_ctrl.md
Name: rcv_ctrl

Overview:
- Control and data path of the UART receive chain; pairs with the existing bit timer (divide-by-10 shift strobe, 9-strobe packet_done).
- Synchronises serial_in, detects the start edge, drives enable_timer, shifts bits on each shift_enable and checks the stop bit on packet_done.
- Loads rx_data and manages data_ready, overrun_error and framing_error toward the host-side reader.

Parameters:
- DATA_BITS, 8, data bits per frame. Frame length is DATA_BITS+1 (data + stop) and must equal the timer's 9-strobe length.
- SYNC_STAGES, 2, flops in the serial_in synchroniser (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- serial_in  in  1  raw RX line, idle high
- shift_enable  in  1  timer strobe, one cycle per bit period
- packet_done  in  1  timer frame-complete flag; may stay high for several cycles
- data_read  in  1  host has consumed rx_data (pulse)
- enable_timer  out  1  runs the timer; low also clears its counters
- rx_data  out  DATA_BITS  last good received byte
- data_ready  out  1  rx_data valid and unread
- overrun_error  out  1  new frame loaded while data_ready was still high
- framing_error  out  1  last frame's stop bit sampled 0

Behaviour:
- Reset values:
  - rx_data = all ones; data_ready, overrun_error, framing_error, enable_timer = 0.
  - Synchroniser and shift register are all ones; FSM is in IDLE.
- Synchroniser: SYNC_STAGES flops. The edge detector compares the last stage with one extra history flop. start_edge = prev & ~cur (1 to 0).
- FSM states:
  - IDLE: enable_timer = 0. On start_edge go to START.
  - START: single cycle. Clears framing_error, sets shift register to all ones, then goes to RECV.
  - RECV: enable_timer = 1. On each shift_enable, shift right with synced serial_in into the MSB. On the first cycle packet_done = 1, go to STOP_CHK. If shift_enable and packet_done arrive in the same cycle, the shift happens first and the transition happens the same cycle.
  - STOP_CHK: enable_timer = 0, which clears the timer so packet_done falls. Stop bit is sreg[DATA_BITS]. If 0: set framing_error and go to IDLE with no load. If 1: go to LOAD.
  - LOAD: single cycle. rx_data <= sreg[DATA_BITS-1:0]. If data_ready is already 1, set overrun_error. data_ready <= 1. Go to IDLE.
- Bit order: LSB first. After DATA_BITS+1 shifts, sreg[0] = d0 and sreg[DATA_BITS] = stop.
- data_read:
  - Clears data_ready and overrun_error next cycle.
  - If data_read coincides with LOAD: LOAD wins. data_ready stays 1 and overrun_error is not set, because the old byte counts as read.
- framing_error holds until the next START. It never blocks later frames.
- start_edge outside IDLE is ignored.
- A glitch that returns high before the timer is not filtered. The frame completes and is judged only by its stop bit.
- Latency: rx_data and data_ready update 2 cycles after the first packet_done cycle (STOP_CHK, then LOAD).
- rst mid-frame: immediate return to reset values. The timer is cleared via enable_timer = 0.

Optional Feature:
- Macro: RCV_BREAK_DETECT_EN.
- Defined:
  - Adds output break_detect (1 bit, reset 0).
  - In STOP_CHK, if sreg is all zeros (data 0 and stop 0), set break_detect and framing_error.
  - FSM then waits in IDLE until synced serial_in is 1 before accepting a new start_edge.
  - break_detect clears on the next START.
- Undefined: port absent. An all-zero frame is an ordinary framing error, and a new start_edge may occur as soon as the line toggles.

Decomposition:
- Package rcv_pkg:
  - state enum rcv_state_t (IDLE, START, RECV, STOP_CHK, LOAD)
  - localparam FRAME_BITS = DATA_BITS+1
  - localparam RX_IDLE_VAL = all ones
- Sub-module rcv_sync_edge: parameterised synchroniser plus falling-edge detector. Outputs sync_out and start_edge.
- The shift register and FSM stay in rcv_ctrl.

Test Plan:
- Good frame 0xA5 (LSB first, stop 1) with a timer model giving 10-clk strobes -> rx_data = 8'hA5, data_ready = 1 two cycles after packet_done, framing_error = 0, enable_timer low from STOP_CHK.
- Frame 0x3C with stop bit 0 -> framing_error = 1, rx_data unchanged (8'hFF after reset), data_ready = 0. Next good frame 0x11 -> framing_error = 0, rx_data = 8'h11.
- Two frames 0x01 then 0x02 with no data_read -> rx_data = 8'h02, overrun_error = 1. data_read pulse -> data_ready = 0 and overrun_error = 0 next cycle.
- data_read asserted exactly in the LOAD cycle of frame 0x55 -> data_ready = 1, overrun_error = 0.
- rst pulsed during the 5th bit of a frame -> all outputs at reset values immediately, enable_timer = 0. The following full frame 0x7E is received correctly.
- RCV_BREAK_DETECT_EN defined: 10 zero bits -> break_detect = 1, framing_error = 1. A start_edge while the line is still low is ignored. After the line goes high, frame 0x42 -> rx_data = 8'h42 and break_detect = 0.
